// File: rtl/segment_message_scroller.sv
// Scrolls a stored message of character codes across two 7-segment digits,
// free-running on a prescaler or single-stepped, with a runtime write port.
module segment_message_scroller #(
  parameter int unsigned CLKS_PER_STEP = 12500000,
  parameter int unsigned ADDR_W        = 3,
  parameter int unsigned GAP_STEPS     = 2,
  parameter logic [7:0]  BLANK_CODE    = 8'h20
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Run_Toggle,
  input  logic              i_Step,
  input  logic              i_Load_En,
  input  logic [ADDR_W-1:0] i_Load_Addr,
  input  logic [7:0]        i_Load_Data,
  output logic [7:0]        o_Char_Left,
  output logic [7:0]        o_Char_Right,
  output logic              o_Running,
  output logic              o_Wrap
);

  localparam int unsigned MSG_LEN = 1 << ADDR_W;
  localparam int unsigned TOTAL   = MSG_LEN + GAP_STEPS;
  localparam int unsigned POS_W   = $clog2(TOTAL);
  localparam int unsigned PRE_W   = $clog2(CLKS_PER_STEP);

  typedef enum logic {
    ST_STOPPED = 1'b0,
    ST_RUN     = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [7:0]         mem_q [MSG_LEN];
  logic               run_prev_q, step_prev_q;
  logic               wrap_pend_q, wrap_pend_d;
  logic [7:0]         char_left_q, char_left_d;
  logic [7:0]         char_right_q, char_right_d;
  logic               running_q, wrap_q;

  logic               run_rise_c, step_rise_c, adv_c;
  logic [POS_W-1:0]   pos_nxt_c;

  assign run_rise_c  = i_Run_Toggle & ~run_prev_q;
  assign step_rise_c = i_Step & ~step_prev_q;
  assign pos_nxt_c   = (pos_q == POS_W'(TOTAL - 1)) ? '0 : pos_q + POS_W'(1);

  // Run/stop sequencing; a toggle always beats a step or prescaler advance.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    adv_c   = 1'b0;
    unique case (state_q)
      ST_STOPPED: begin
        if (run_rise_c) begin
          state_d = ST_RUN;
          pre_d   = '0;
        end else if (step_rise_c) begin
          adv_c = 1'b1;
        end
      end
      ST_RUN: begin
        if (run_rise_c) begin
          state_d = ST_STOPPED;
        end else if (pre_q == PRE_W'(CLKS_PER_STEP - 1)) begin
          pre_d = '0;
          adv_c = 1'b1;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Position, wrap flag and the displayed stream window.
  always_comb begin
    pos_d        = adv_c ? pos_nxt_c : pos_q;
    wrap_pend_d  = adv_c && (pos_q == POS_W'(TOTAL - 1));
    char_left_d  = (pos_q < POS_W'(MSG_LEN)) ? mem_q[pos_q[ADDR_W-1:0]] : BLANK_CODE;
    char_right_d = (pos_nxt_c < POS_W'(MSG_LEN)) ? mem_q[pos_nxt_c[ADDR_W-1:0]] : BLANK_CODE;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q      <= ST_STOPPED;
      pos_q        <= '0;
      pre_q        <= '0;
      run_prev_q   <= 1'b1;
      step_prev_q  <= 1'b1;
      wrap_pend_q  <= 1'b0;
      char_left_q  <= BLANK_CODE;
      char_right_q <= BLANK_CODE;
      running_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      pre_q        <= pre_d;
      run_prev_q   <= i_Run_Toggle;
      step_prev_q  <= i_Step;
      wrap_pend_q  <= wrap_pend_d;
      char_left_q  <= char_left_d;
      char_right_q <= char_right_d;
      running_q    <= (state_q == ST_RUN);
      wrap_q       <= wrap_pend_q;
    end
  end

  // Message memory; reads above see the pre-write contents in the write cycle.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) mem_q[i] <= BLANK_CODE;
    end else if (i_Load_En) begin
      mem_q[i_Load_Addr] <= i_Load_Data;
    end
  end

  assign o_Char_Left  = char_left_q;
  assign o_Char_Right = char_right_q;
  assign o_Running    = running_q;
  assign o_Wrap       = wrap_q;

endmodule

// File: tb/tb_segment_message_scroller.sv
// Directed bench for segment_message_scroller with a 4-clock step and 5-position stream.
module tb_segment_message_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run_tog = 1'b0;
  logic       step = 1'b0;
  logic       load_en = 1'b0;
  logic [1:0] load_addr = 2'd0;
  logic [7:0] load_data = 8'h00;
  logic [7:0] char_l, char_r;
  logic       running, wrap;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_stream [5];

  segment_message_scroller #(
    .CLKS_PER_STEP(4),
    .ADDR_W       (2),
    .GAP_STEPS    (1),
    .BLANK_CODE   (8'h20)
  ) dut (
    .i_Clk       (clk),
    .i_Reset     (rst),
    .i_Run_Toggle(run_tog),
    .i_Step      (step),
    .i_Load_En   (load_en),
    .i_Load_Addr (load_addr),
    .i_Load_Data (load_data),
    .o_Char_Left (char_l),
    .o_Char_Right(char_r),
    .o_Running   (running),
    .o_Wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_mem(input logic [1:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
  endtask

  initial begin
    exp_stream[0] = 8'h41; exp_stream[1] = 8'h42; exp_stream[2] = 8'h43;
    exp_stream[3] = 8'h44; exp_stream[4] = 8'h20;

    // Async reset before any clock edge
    #1 rst = 1'b1;
    #2;
    chk("rst_left", char_l, 8'h20);
    chk("rst_right", char_r, 8'h20);
    chk("rst_running", {7'd0, running}, 8'd0);
    chk("rst_wrap", {7'd0, wrap}, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Load the message
    write_mem(2'd0, 8'h41);
    write_mem(2'd1, 8'h42);
    write_mem(2'd2, 8'h43);
    write_mem(2'd3, 8'h44);
    tick();
    chk("load_left", char_l, 8'h41);
    chk("load_right", char_r, 8'h42);
    chk("load_running", {7'd0, running}, 8'd0);
    chk("load_wrap", {7'd0, wrap}, 8'd0);

    // Single-step through one full revolution
    for (int p = 1; p <= 5; p++) begin
      step_pulse();
      chk($sformatf("step%0d_left", p), char_l, exp_stream[p % 5]);
      chk($sformatf("step%0d_right", p), char_r, exp_stream[(p + 1) % 5]);
      chk($sformatf("step%0d_wrap", p), {7'd0, wrap}, (p == 5) ? 8'd1 : 8'd0);
      tick();
      chk($sformatf("step%0d_hold", p), char_l, exp_stream[p % 5]);
      chk($sformatf("step%0d_wrap_off", p), {7'd0, wrap}, 8'd0);
    end

    // Free run for 21 clocks after entering RUN
    run_tog = 1'b1;
    tick();
    run_tog = 1'b0;
    chk("run_lag", {7'd0, running}, 8'd0);
    for (int n = 1; n <= 21; n++) begin
      tick();
      chk($sformatf("run%0d_left", n), char_l, exp_stream[((n - 1) / 4) % 5]);
      chk($sformatf("run%0d_wrap", n), {7'd0, wrap}, (n == 21) ? 8'd1 : 8'd0);
    end
    chk("run_running", {7'd0, running}, 8'd1);

    // Stop: outputs freeze
    run_tog = 1'b1;
    tick();
    run_tog = 1'b0;
    tick();
    chk("stop_running", {7'd0, running}, 8'd0);
    chk("stop_left", char_l, 8'h41);
    repeat (8) tick();
    chk("stop_frozen_left", char_l, 8'h41);
    chk("stop_frozen_right", char_r, 8'h42);

    // Same-cycle toggle and step: toggle wins, no advance
    run_tog = 1'b1; step = 1'b1;
    tick();
    run_tog = 1'b0; step = 1'b0;
    tick();
    chk("both_left", char_l, 8'h41);
    chk("both_running", {7'd0, running}, 8'd1);
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    chk("runstep_left", char_l, 8'h41);
    tick();
    tick();
    chk("runadv_left", char_l, 8'h42);
    chk("runadv_right", char_r, 8'h43);

    // Overwrite the displayed address while running
    write_mem(2'd1, 8'h5A);
    chk("wr_old_left", char_l, 8'h42);
    tick();
    chk("wr_new_left", char_l, 8'h5A);
    chk("wr_new_right", char_r, 8'h43);
    tick();
    chk("wr_timing_hold", char_l, 8'h5A);
    tick();
    chk("wr_timing_adv_left", char_l, 8'h43);
    chk("wr_timing_adv_right", char_r, 8'h44);

    // Reset mid-run with switches held high
    run_tog = 1'b1; step = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("rst2_left", char_l, 8'h20);
    chk("rst2_right", char_r, 8'h20);
    chk("rst2_running", {7'd0, running}, 8'd0);
    chk("rst2_wrap", {7'd0, wrap}, 8'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) tick();
    chk("rel_running", {7'd0, running}, 8'd0);
    run_tog = 1'b0; step = 1'b0;
    write_mem(2'd0, 8'h61);
    tick();
    chk("rel_pos0_left", char_l, 8'h61);
    chk("rel_pos0_right", char_r, 8'h20);

    // Remaining entries were cleared by reset
    exp_stream[0] = 8'h61; exp_stream[1] = 8'h20; exp_stream[2] = 8'h20;
    exp_stream[3] = 8'h20; exp_stream[4] = 8'h20;
    for (int p = 1; p <= 5; p++) begin
      step_pulse();
      chk($sformatf("clr%0d_left", p), char_l, exp_stream[p % 5]);
      chk($sformatf("clr%0d_right", p), char_r, exp_stream[(p + 1) % 5]);
    end
    chk("clr_wrap", {7'd0, wrap}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/segment_message_scroller.md
Name: segment_message_scroller

Overview:
- Sequencer that scrolls a stored message of character codes across the board's two 7-segment digits, one position per step.
- Sits between the debounced switch inputs and the two character-decoder instances; drives their 8-bit character-select inputs.
- Supports free-run or single-step, plus a write port for loading the message at runtime.

Parameters:
- CLKS_PER_STEP, 12500000: clocks per scroll step while running (0.5 s at 25 MHz); minimum 2.
- ADDR_W, 3: message address width; MSG_LEN = 2**ADDR_W characters.
- GAP_STEPS, 2: number of blank positions appended after the message before it repeats; minimum 1.
- BLANK_CODE, 8'h20: character code shown for blank/gap positions.

Ports:
- i_Clk, input, 1: system clock.
- i_Reset, input, 1: asynchronous, active-high reset.
- i_Run_Toggle, input, 1: debounced switch level; each rising edge toggles run/stop.
- i_Step, input, 1: debounced switch level; each rising edge advances one position while stopped.
- i_Load_En, input, 1: write strobe for the message memory.
- i_Load_Addr, input, ADDR_W: write address.
- i_Load_Data, input, 8: character code to write.
- o_Char_Left, output, 8: character code for digit 1.
- o_Char_Right, output, 8: character code for digit 2.
- o_Running, output, 1: high while in RUN.
- o_Wrap, output, 1: one-cycle pulse when the scroll position wraps to 0.

Behaviour:
- Stream definition:
  - TOTAL = MSG_LEN + GAP_STEPS.
  - stream[k] = mem[k] for k < MSG_LEN; stream[k] = BLANK_CODE otherwise.
  - Position register pos ranges 0..TOTAL-1.
- Outputs are registered:
  - o_Char_Left = stream[pos]; o_Char_Right = stream[(pos+1) mod TOTAL].
  - Both reflect pos and mem with exactly 1 cycle of latency.
- Reset (async, while asserted):
  - State STOPPED; pos = 0; prescaler = 0; all mem entries = BLANK_CODE.
  - o_Char_Left = o_Char_Right = BLANK_CODE; o_Running = 0; o_Wrap = 0.
  - Edge-detect history registers reset to 1, so a switch held through reset release produces no edge.
  - Reset mid-step or mid-load aborts it; the write in that cycle is discarded.
- Edge detection: rise = input & ~prev, with prev registered every clock.
- FSM:
  - STOPPED:
    - Run_Toggle rise -> RUN, prescaler cleared to 0.
    - Step rise (no simultaneous toggle rise) -> advance pos once, stay STOPPED.
    - Toggle and step rise in the same cycle: toggle wins, step is dropped.
  - RUN:
    - prescaler increments each clock.
    - At CLKS_PER_STEP-1: prescaler -> 0 and pos advances.
    - Step rises are ignored.
    - Run_Toggle rise -> STOPPED; prescaler held at its value, pos unchanged. This has priority over an advance in the same cycle.
- Advance: pos = (pos == TOTAL-1) ? 0 : pos+1.
  - o_Wrap pulses high 1 cycle later, aligned with the output update showing pos 0.
- o_Running: registered, equals (state == RUN), so it follows the state change by 1 cycle.
- Load:
  - When i_Load_En is high, mem[i_Load_Addr] <= i_Load_Data at the clock edge.
  - Allowed in any state and in the same cycle as an advance.
  - A displayed address shows the new value on the output 1 cycle after the write edge.
  - A write and a read of the same address in the same cycle: the output shows the old value that cycle and the new value the next.
- Prescaler width: clog2(CLKS_PER_STEP); it never exceeds CLKS_PER_STEP-1.

Test Plan (CLKS_PER_STEP=4, ADDR_W=2, GAP_STEPS=1, BLANK_CODE=8'h20, TOTAL=5):
- Reset, then load addr0..3 = 8'h41,42,43,44 -> after the last write +1 cycle: Left=8'h41, Right=8'h42; o_Running=0; o_Wrap=0.
- Pulse i_Step 5 times while stopped -> Left/Right sequence 42/43, 43/44, 44/20, 20/41, 41/42; o_Wrap high for exactly 1 cycle at the 41/42 update; no change between pulses.
- Toggle run -> o_Running=1 next cycle; pos advances every 4 clocks; 20 clocks after entering RUN, pos is back at 0 with one o_Wrap pulse. Toggle again -> outputs frozen, o_Running=0.
- Same-cycle Run_Toggle and Step rises while stopped -> enters RUN, pos unchanged. While running, Step rises produce no extra advance.
- While running with Left showing addr1, write addr1 = 8'h5A -> Left = 8'h5A 1 cycle after the write; scroll timing is unaffected.
- Assert i_Reset mid-run with the switch inputs held high -> outputs go to 8'h20 immediately (async). After release: STOPPED, no spurious edge, and all mem entries read 8'h20 when stepped through.
